// File: rtl/flash_avmm_master_pkg.sv
// Shared types and constants for the MAX10 on-chip flash Avalon-MM initiator:
// command op codes, controller states, CSR addresses and status bit positions.
package flash_avmm_master_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_UNLOCK,
    S_WR_REQ,
    S_POLL_RD,
    S_POLL_CHK,
    S_LOCK,
    S_DONE
  } state_e;

  localparam logic CSR_STATUS  = 1'b0;
  localparam logic CSR_CONTROL = 1'b1;

  localparam int ST_ERASE_OK = 4;
  localparam int ST_WRITE_OK = 3;
  localparam int ST_READ_OK  = 2;

  localparam logic [31:0] CONTROL_LOCKED = 32'hFFFF_FFFF;
  localparam logic [19:0] PAGE_NONE      = 20'hF_FFFF;

  // Control register image: sector-erase field is always "none" for this initiator.
  function automatic logic [31:0] control_word(input logic [4:0] wp, input logic [19:0] page);
    return {4'hF, wp, 3'b111, page};
  endfunction

endpackage

// File: rtl/flash_avmm_master_if.sv
// Command/response handshake plus the Avalon-MM data and CSR master buses of the
// flash initiator; master is the initiator's view, slave the environment's view.
interface flash_avmm_master_if #(
  parameter int ADDR_W = 19
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;

  logic [ADDR_W-1:0] avmm_data_addr;
  logic              avmm_data_read;
  logic              avmm_data_write;
  logic [31:0]       avmm_data_writedata;
  logic [3:0]        avmm_data_burstcount;
  logic [31:0]       avmm_data_readdata;
  logic              avmm_data_waitrequest;
  logic              avmm_data_readdatavalid;

  logic              avmm_csr_addr;
  logic              avmm_csr_read;
  logic              avmm_csr_write;
  logic [31:0]       avmm_csr_writedata;
  logic [31:0]       avmm_csr_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
    output avmm_data_burstcount,
    input  avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid,
    output avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    input  avmm_csr_readdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
    input  avmm_data_burstcount,
    output avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid,
    input  avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    output avmm_csr_readdata
  );

endinterface

// File: rtl/flash_avmm_master.sv
// Avalon-MM initiator for the MAX10 on-chip flash: turns single-word read/write/erase
// commands into data-slave accesses bracketed by CSR write-protect unlock and relock.
//
// state      | meaning
// S_IDLE     | ready for a command
// S_RD_REQ   | data read asserted until accepted
// S_RD_WAIT  | waiting for readdatavalid
// S_UNLOCK   | CSR control write opening WP (and page erase address)
// S_WR_REQ   | data write asserted until accepted
// S_POLL_RD  | CSR status read issued
// S_POLL_CHK | status returned, check busy / ok bit
// S_LOCK     | CSR control write restoring full write protection
// S_DONE     | one-cycle response
module flash_avmm_master
  import flash_avmm_master_pkg::*;
#(
  parameter int          ADDR_W    = 19,
  parameter logic [4:0]  WP_UNLOCK = 5'b00000,
  parameter logic [19:0] TIMEOUT   = 20'hF_FFFF
) (
  input logic                 clock_i,
  input logic                 reset_n_i,
  flash_avmm_master_if.master bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [19:0]       cnt_q, cnt_d;
  logic              run_q;
  logic              tc;
  logic              poll_loop;
  logic              op_ok;

  assign tc = (cnt_q == 20'd0);
  assign op_ok = (op_q == OP_ERASE) ? bus.avmm_csr_readdata[ST_ERASE_OK]
                                    : bus.avmm_csr_readdata[ST_WRITE_OK];

  assign bus.avmm_data_addr       = addr_q;
  assign bus.avmm_data_writedata  = wdata_q;
  assign bus.avmm_data_burstcount = 4'd1;
  assign bus.rsp_rdata            = rdata_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    bus.cmd_ready          = 1'b0;
    bus.rsp_valid          = 1'b0;
    bus.rsp_error          = 1'b0;
    bus.avmm_data_read     = 1'b0;
    bus.avmm_data_write    = 1'b0;
    bus.avmm_csr_addr      = CSR_STATUS;
    bus.avmm_csr_read      = 1'b0;
    bus.avmm_csr_write     = 1'b0;
    bus.avmm_csr_writedata = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = run_q;
        if (run_q && bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          rdata_d = '0;
          err_d   = (op_e'(bus.cmd_op) == OP_RSVD);
          unique case (op_e'(bus.cmd_op))
            OP_READ:  state_d = S_RD_REQ;
            OP_WRITE: state_d = S_UNLOCK;
            OP_ERASE: state_d = S_UNLOCK;
            default:  state_d = S_DONE;
          endcase
        end
      end
      S_RD_REQ: begin
        bus.avmm_data_read = 1'b1;
        if (!bus.avmm_data_waitrequest) begin
          if (bus.avmm_data_readdatavalid) begin
            rdata_d = bus.avmm_data_readdata;
            state_d = S_DONE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RD_WAIT: begin
        if (bus.avmm_data_readdatavalid) begin
          rdata_d = bus.avmm_data_readdata;
          state_d = S_DONE;
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_UNLOCK: begin
        bus.avmm_csr_write     = 1'b1;
        bus.avmm_csr_addr      = CSR_CONTROL;
        bus.avmm_csr_writedata = control_word(WP_UNLOCK,
                                   (op_q == OP_ERASE) ? 20'(addr_q) : PAGE_NONE);
        state_d = (op_q == OP_WRITE) ? S_WR_REQ : S_POLL_RD;
      end
      S_WR_REQ: begin
        bus.avmm_data_write = 1'b1;
        if (!bus.avmm_data_waitrequest) begin
          state_d = S_POLL_RD;
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = S_LOCK;
        end
      end
      S_POLL_RD: begin
        bus.avmm_csr_read = 1'b1;
        if (tc) begin
          err_d   = 1'b1;
          state_d = S_LOCK;
        end else begin
          state_d = S_POLL_CHK;
        end
      end
      S_POLL_CHK: begin
        if (bus.avmm_csr_readdata[1:0] == 2'b00) begin
          err_d   = err_q | ~op_ok;
          state_d = S_LOCK;
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = S_LOCK;
        end else begin
          state_d = S_POLL_RD;
        end
      end
      S_LOCK: begin
        bus.avmm_csr_write     = 1'b1;
        bus.avmm_csr_addr      = CSR_CONTROL;
        bus.avmm_csr_writedata = CONTROL_LOCKED;
        state_d = S_DONE;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_error = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The poll loop counts as one wait, otherwise a flash stuck busy would never time out.
  always_comb begin
    poll_loop = ((state_q == S_POLL_RD) && (state_d == S_POLL_CHK)) ||
                ((state_q == S_POLL_CHK) && (state_d == S_POLL_RD));
    if ((state_d != state_q) && !poll_loop) begin
      cnt_d = TIMEOUT - 20'd1;
    end else if (!tc) begin
      cnt_d = cnt_q - 20'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_flash_avmm_master.sv
// Bench for flash_avmm_master: a reactive Avalon data/CSR slave plus a transaction-level
// reference model of the command flows, checked per scenario task.
module tb_flash_avmm_master;
  import flash_avmm_master_pkg::*;

  localparam int          ADDR_W = 19;
  localparam logic [19:0] TMO    = 20'd16;
  localparam int          BUDGET = 200;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  flash_avmm_master_if #(.ADDR_W(ADDR_W)) bus ();

  flash_avmm_master #(
    .ADDR_W   (ADDR_W),
    .WP_UNLOCK(5'b00000),
    .TIMEOUT  (TMO)
  ) dut (
    .clock_i  (clock),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  // slave behaviour knobs
  int          wait_cfg    = 0;
  int          lat_cfg     = 1;
  logic [31:0] rd_data_cfg = 32'h0;
  bit          stuck       = 1'b0;
  logic [31:0] poll_q[$];
  logic [31:0] poll_last   = 32'h0;

  // observations
  logic [32:0]       csr_log[$];
  logic [ADDR_W+31:0] data_log[$];
  int          rd_cycles, wr_cycles, csr_rd_cnt, rsp_cnt, viol;
  logic [31:0] rsp_rdata_seen;
  logic        rsp_err_seen;
  int          wcnt, rdv_t;
  bit          hold_prev;
  logic [ADDR_W-1:0] addr_prev;
  logic [31:0] wd_prev;

  function automatic bit eq33(input logic [32:0] a[$], input logic [32:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Slave and monitor: samples DUT outputs on the falling edge, answers for the next rising edge.
  initial begin
    bus.avmm_data_readdata      = '0;
    bus.avmm_data_waitrequest   = 1'b1;
    bus.avmm_data_readdatavalid = 1'b0;
    bus.avmm_csr_readdata       = '0;
    wcnt = 0; rdv_t = -1; hold_prev = 1'b0; viol = 0;
    rd_cycles = 0; wr_cycles = 0; csr_rd_cnt = 0; rsp_cnt = 0;
    rsp_rdata_seen = '0; rsp_err_seen = 1'b0;
    forever begin
      @(negedge clock);
      bus.avmm_data_readdatavalid = 1'b0;
      if (!reset_n) begin
        wcnt = 0; rdv_t = -1; hold_prev = 1'b0;
      end else begin
        if (rdv_t > 0) begin
          rdv_t--;
          if (rdv_t == 0) begin
            bus.avmm_data_readdatavalid = 1'b1;
            bus.avmm_data_readdata      = rd_data_cfg;
            rdv_t = -1;
          end
        end
        if (hold_prev && (bus.avmm_data_read || bus.avmm_data_write) &&
            (bus.avmm_data_addr !== addr_prev || bus.avmm_data_writedata !== wd_prev)) viol++;
        hold_prev = 1'b0;
        if (bus.avmm_data_read && bus.avmm_data_write) viol++;
        if (bus.avmm_data_burstcount !== 4'd1) viol++;
        if (bus.avmm_data_read || bus.avmm_data_write) begin
          if (bus.avmm_data_read) rd_cycles++;
          if (bus.avmm_data_write) wr_cycles++;
          if (bus.avmm_data_read && rdv_t != -1) viol++;
          if (stuck || wcnt < wait_cfg) begin
            bus.avmm_data_waitrequest = 1'b1;
            wcnt++;
            hold_prev = 1'b1;
            addr_prev = bus.avmm_data_addr;
            wd_prev   = bus.avmm_data_writedata;
          end else begin
            bus.avmm_data_waitrequest = 1'b0;
            wcnt = 0;
            if (bus.avmm_data_write) data_log.push_back({bus.avmm_data_addr, bus.avmm_data_writedata});
            if (bus.avmm_data_read) begin
              if (lat_cfg == 0) begin
                bus.avmm_data_readdatavalid = 1'b1;
                bus.avmm_data_readdata      = rd_data_cfg;
              end else begin
                rdv_t = lat_cfg;
              end
            end
          end
        end else begin
          bus.avmm_data_waitrequest = 1'b1;
          wcnt = 0;
        end
        if (bus.avmm_csr_read && bus.avmm_csr_write) viol++;
        if (bus.avmm_csr_read) begin
          csr_rd_cnt++;
          bus.avmm_csr_readdata = (poll_q.size() > 0) ? poll_q.pop_front() : poll_last;
        end
        if (bus.avmm_csr_write) csr_log.push_back({bus.avmm_csr_addr, bus.avmm_csr_writedata});
        if (bus.rsp_error && !bus.rsp_valid) viol++;
        if (bus.rsp_valid) begin
          rsp_cnt++;
          rsp_rdata_seen = bus.rsp_rdata;
          rsp_err_seen   = bus.rsp_error;
        end
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         output bit got, output int lat);
    @(negedge clock); #1;
    csr_log.delete(); data_log.delete();
    rd_cycles = 0; wr_cycles = 0; csr_rd_cnt = 0; rsp_cnt = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = wd;
    @(negedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_addr = ADDR_W'($urandom); bus.cmd_wdata = $urandom;
    lat = 1;
    got = (rsp_cnt > 0);
    while (!got && lat < BUDGET) begin
      @(negedge clock); #1;
      lat++;
      got = (rsp_cnt > 0);
    end
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_error, bus.avmm_data_read, bus.avmm_data_write,
         bus.avmm_csr_read, bus.avmm_csr_write} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {bus.cmd_ready, bus.rsp_valid,
        bus.rsp_error, bus.avmm_data_read, bus.avmm_data_write, bus.avmm_csr_read, bus.avmm_csr_write});
    end
    reset_n = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.avmm_data_burstcount !== 4'd1) begin
      errors++; $display("FAIL reset_release ready %b burst %0d exp 1/1", bus.cmd_ready, bus.avmm_data_burstcount);
    end
  endtask

  task automatic test_read();
    bit got; int lat;
    wait_cfg = 3; lat_cfg = 2; rd_data_cfg = 32'hA5A5_1234; stuck = 1'b0;
    run_cmd(2'b00, 19'h00010, 32'h0, got, lat);
    checks++;
    if (!got || rsp_cnt != 1) begin errors++; $display("FAIL read_rsp got %0d pulses exp 1", rsp_cnt); end
    checks++;
    if (rsp_rdata_seen !== 32'hA5A5_1234 || rsp_err_seen !== 1'b0) begin
      errors++; $display("FAIL read_data got %h err %b exp a5a51234 err 0", rsp_rdata_seen, rsp_err_seen);
    end
    checks++;
    if (rd_cycles != 4 || csr_log.size() != 0) begin
      errors++; $display("FAIL read_strobe got %0d read cycles %0d csr writes exp 4/0", rd_cycles, csr_log.size());
    end
  endtask

  task automatic test_write();
    bit got; int lat; logic [32:0] exp_csr[$];
    wait_cfg = 3; stuck = 1'b0; poll_q.delete();
    repeat (5) poll_q.push_back(32'h2);
    poll_last = 32'h08;
    exp_csr = '{33'h1_F07F_FFFF, 33'h1_FFFF_FFFF};
    run_cmd(2'b01, 19'h00100, 32'hDEAD_BEEF, got, lat);
    checks++;
    if (!got || rsp_cnt != 1 || rsp_err_seen !== 1'b0) begin
      errors++; $display("FAIL write_rsp got %0d pulses err %b exp 1 err 0", rsp_cnt, rsp_err_seen);
    end
    checks++;
    if (!eq33(csr_log, exp_csr)) begin
      errors++; $display("FAIL write_csr got %0d writes exp 2 (unlock f07fffff, lock ffffffff)", csr_log.size());
    end
    checks++;
    if (data_log.size() != 1 || data_log[0] !== {19'h00100, 32'hDEAD_BEEF} || wr_cycles != 4) begin
      errors++; $display("FAIL write_data got %0d accepts %0d cycles exp 1/4", data_log.size(), wr_cycles);
    end
    checks++;
    if (csr_rd_cnt != 6) begin errors++; $display("FAIL write_polls got %0d exp 6", csr_rd_cnt); end
  endtask

  task automatic test_erase();
    bit got; int lat; logic [32:0] exp_csr[$];
    stuck = 1'b0; poll_q.delete();
    repeat (2) poll_q.push_back(32'h1);
    poll_last = 32'h00;
    exp_csr = '{33'h1_F070_1234, 33'h1_FFFF_FFFF};
    run_cmd(2'b10, 19'h01234, 32'h0, got, lat);
    checks++;
    if (!got || rsp_err_seen !== 1'b1) begin errors++; $display("FAIL erase_rsp got err %b exp 1", rsp_err_seen); end
    checks++;
    if (!eq33(csr_log, exp_csr) || data_log.size() != 0 || rd_cycles != 0) begin
      errors++; $display("FAIL erase_csr got %0d csr writes %0d data exp 2/0", csr_log.size(), data_log.size());
    end
  endtask

  task automatic test_reserved();
    bit got; int lat;
    run_cmd(2'b11, 19'h7ABCD, 32'h1234_5678, got, lat);
    checks++;
    if (!got || lat > 2 || rsp_err_seen !== 1'b1 || rsp_cnt != 1) begin
      errors++; $display("FAIL rsvd_rsp got lat %0d err %b pulses %0d exp <=2/1/1", lat, rsp_err_seen, rsp_cnt);
    end
    checks++;
    if (rd_cycles + wr_cycles + csr_rd_cnt + csr_log.size() != 0) begin
      errors++; $display("FAIL rsvd_quiet got %0d strobes exp 0", rd_cycles + wr_cycles + csr_rd_cnt + csr_log.size());
    end
  endtask

  task automatic test_timeouts();
    bit got; int lat; logic [32:0] exp_csr[$];
    stuck = 1'b1;
    exp_csr = '{33'h1_F07F_FFFF, 33'h1_FFFF_FFFF};
    run_cmd(2'b01, 19'h00042, 32'h0BAD_F00D, got, lat);
    checks++;
    if (!got || wr_cycles != 16 || rsp_err_seen !== 1'b1 || !eq33(csr_log, exp_csr) || data_log.size() != 0) begin
      errors++; $display("FAIL tmo_write got %0d cycles err %b csr %0d exp 16/1/2", wr_cycles, rsp_err_seen, csr_log.size());
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready got %b exp 1", bus.cmd_ready); end
    run_cmd(2'b00, 19'h00007, 32'h0, got, lat);
    checks++;
    if (!got || rd_cycles != 16 || rsp_err_seen !== 1'b1 || csr_log.size() != 0) begin
      errors++; $display("FAIL tmo_read got %0d cycles err %b exp 16/1", rd_cycles, rsp_err_seen);
    end
    stuck = 1'b0; poll_q.delete(); poll_last = 32'h1;
    exp_csr = '{33'h1_F070_0055, 33'h1_FFFF_FFFF};
    run_cmd(2'b10, 19'h00055, 32'h0, got, lat);
    checks++;
    if (!got || csr_rd_cnt != 8 || rsp_err_seen !== 1'b1 || !eq33(csr_log, exp_csr)) begin
      errors++; $display("FAIL tmo_poll got %0d polls err %b exp 8/1", csr_rd_cnt, rsp_err_seen);
    end
  endtask

  task automatic test_reset_mid();
    bit seen; bit got; int lat;
    stuck = 1'b0; wait_cfg = 1; poll_q.delete(); poll_last = 32'h2;
    @(negedge clock); #1;
    csr_rd_cnt = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_addr = 19'h00321; bus.cmd_wdata = 32'hCAFE_0001;
    @(negedge clock); #1;
    bus.cmd_valid = 1'b0;
    seen = (csr_rd_cnt >= 2);
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clock); #1;
      seen = (csr_rd_cnt >= 2);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_poll got %0d polls exp >=2", csr_rd_cnt); end
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_error, bus.avmm_data_read, bus.avmm_data_write,
         bus.avmm_csr_read, bus.avmm_csr_write, bus.avmm_csr_addr, bus.avmm_csr_writedata,
         bus.avmm_data_addr, bus.avmm_data_writedata, bus.rsp_rdata} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got ready %b csr_wr %b data_addr %h wdata %h exp all 0",
        bus.cmd_ready, bus.avmm_csr_write, bus.avmm_data_addr, bus.avmm_data_writedata);
    end
    repeat (2) @(negedge clock);
    #1;
    poll_q.delete();
    reset_n = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.cmd_ready); end
    wait_cfg = 0; lat_cfg = 1; rd_data_cfg = 32'h1357_9BDF;
    run_cmd(2'b00, 19'h00abc, 32'h0, got, lat);
    checks++;
    if (!got || rsp_rdata_seen !== 32'h1357_9BDF || rsp_err_seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_read got %h err %b exp 13579bdf err 0", rsp_rdata_seen, rsp_err_seen);
    end
  endtask

  task automatic test_random(input int n);
    logic [1:0] op; logic [ADDR_W-1:0] a; logic [31:0] wd, fin, b;
    int nbusy, exp_polls, exp_rd, exp_data; bit got, exp_err; int lat;
    logic [32:0] exp_csr[$];
    for (int it = 0; it < n; it++) begin
      op = 2'($urandom_range(0, 3)); a = ADDR_W'($urandom); wd = $urandom;
      wait_cfg = $urandom_range(0, 4); lat_cfg = $urandom_range(0, 4);
      rd_data_cfg = $urandom; stuck = 1'b0;
      nbusy = $urandom_range(0, 6); poll_q.delete();
      for (int k = 0; k < nbusy; k++) begin
        b = $urandom; b[1:0] = 2'($urandom_range(1, 3)); poll_q.push_back(b);
      end
      fin = $urandom; fin[1:0] = 2'b00; poll_last = fin;
      exp_csr.delete(); exp_polls = 0; exp_rd = 0; exp_data = 0; exp_err = 1'b0;
      case (op)
        2'b00: exp_rd = wait_cfg + 1;
        2'b01: begin
          exp_csr = '{33'h1_F07F_FFFF, 33'h1_FFFF_FFFF};
          exp_polls = nbusy + 1; exp_data = 1; exp_err = ~fin[3];
        end
        2'b10: begin
          exp_csr = '{{1'b1, 32'hF070_0000 | 32'(a)}, 33'h1_FFFF_FFFF};
          exp_polls = nbusy + 1; exp_err = ~fin[4];
        end
        default: exp_err = 1'b1;
      endcase
      run_cmd(op, a, wd, got, lat);
      checks++;
      if (!got || rsp_cnt != 1 || rsp_err_seen !== exp_err) begin
        errors++; $display("FAIL rnd_rsp[%0d] op %0d got pulses %0d err %b exp 1 err %b", it, op, rsp_cnt, rsp_err_seen, exp_err);
      end
      checks++;
      if (!eq33(csr_log, exp_csr) || csr_rd_cnt != exp_polls) begin
        errors++; $display("FAIL rnd_csr[%0d] op %0d got %0d writes %0d polls exp %0d/%0d", it, op, csr_log.size(), csr_rd_cnt, exp_csr.size(), exp_polls);
      end
      checks++;
      if (data_log.size() != exp_data || rd_cycles != exp_rd ||
          (exp_data == 1 && data_log[0] !== {a, wd})) begin
        errors++; $display("FAIL rnd_data[%0d] op %0d got %0d accepts %0d rd cycles exp %0d/%0d", it, op, data_log.size(), rd_cycles, exp_data, exp_rd);
      end
      if (op == 2'b00) begin
        checks++;
        if (rsp_rdata_seen !== rd_data_cfg) begin
          errors++; $display("FAIL rnd_rdata[%0d] got %h exp %h", it, rsp_rdata_seen, rd_data_cfg);
        end
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL avalon_rules got %0d violations exp 0", viol); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    test_reset();
    test_read();
    test_write();
    test_erase();
    test_reserved();
    test_timeouts();
    test_reset_mid();
    test_random(40);
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
